// File: rtl/aig_bist_pkg.sv
// Shared types, tap constants and step functions for the AIG benchmark BIST.
package aig_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } bist_state_t;

  // Feedback masks: bit positions are (tap - 1).
  // LFSR30 taps 30,6,4,1 -> bits 29,5,3,0.
  localparam logic [29:0] LFSR30_TAPS = 30'h2000_0029;
  // MISR26 taps 26,6,2,1 -> bits 25,5,1,0.
  localparam logic [25:0] MISR26_TAPS = 26'h200_0023;

  // Fibonacci LFSR step: shift left, XOR of tapped bits enters at bit 0.
  function automatic logic [29:0] lfsr30_next(input logic [29:0] s);
    return {s[28:0], ^(s & LFSR30_TAPS)};
  endfunction

  // MISR step: same shift/feedback form, then fold in the response word.
  function automatic logic [25:0] misr26_next(input logic [25:0] m,
                                              input logic [25:0] d);
    return {m[24:0], ^(m & MISR26_TAPS)} ^ d;
  endfunction

endpackage

// File: rtl/aig_bist_misr.sv
// Width-generic multiple-input signature register with synchronous load.
module aig_bist_misr
  import aig_bist_pkg::*;
#(
  parameter int unsigned   W    = 26,
  parameter logic [W-1:0]  TAPS = W'(MISR26_TAPS)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic         i_en,
  input  logic [W-1:0] i_seed,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_sig
);

  logic [W-1:0] r_sig;
  logic         w_fb;

  assign w_fb  = ^(r_sig & TAPS);
  assign o_sig = r_sig;

  // Signature register: load has priority over compaction.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sig <= '0;
    end else if (i_load) begin
      r_sig <= i_seed;
    end else if (i_en) begin
      r_sig <= {r_sig[W-2:0], w_fb} ^ i_data;
    end
  end

endmodule

// File: rtl/aig_bench_bist.sv
// LFSR-driven, MISR-compacted self-test harness for one AIG benchmark netlist.
module aig_bench_bist
  import aig_bist_pkg::*;
#(
  parameter int unsigned       IN_W      = 30,
  parameter int unsigned       OUT_W     = 26,
  parameter int unsigned       CNT_W     = 16,
  parameter int unsigned       DUT_LAT   = 0,
  parameter logic [IN_W-1:0]   LFSR_SEED = IN_W'(1),
  parameter logic [OUT_W-1:0]  MISR_SEED = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_patterns,
  input  logic [OUT_W-1:0] golden,
  output logic [IN_W-1:0]  x_out,
  input  logic [OUT_W-1:0] f_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [OUT_W-1:0] signature
);

  bist_state_t      r_state;
  bist_state_t      w_state_nxt;
  logic [IN_W-1:0]  r_lfsr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pass;
  logic             w_start_acc;
  logic             w_abort_act;
  logic             w_issue;
  logic             w_load_lfsr;
  logic             w_cap_valid;
  logic             w_drained;
  logic [OUT_W-1:0] w_sig;

  assign w_start_acc = (r_state == ST_IDLE) && start;
  assign w_abort_act = abort && ((r_state == ST_RUN) || (r_state == ST_DRAIN));
  // An aborting RUN cycle issues nothing, so x_out and the signature freeze.
  assign w_issue     = (r_state == ST_RUN) && !abort;
  // A zero-length run leaves x_out untouched.
  assign w_load_lfsr = w_start_acc && (num_patterns != '0);

  // Capture-valid: the issue flag itself, or the issue flag delayed DUT_LAT cycles.
  if (DUT_LAT == 0) begin : g_nolat
    assign w_cap_valid = w_issue;
    assign w_drained   = 1'b1;
  end else begin : g_lat
    logic [DUT_LAT-1:0] r_vpipe;
    logic [DUT_LAT-1:0] w_vpipe_nxt;

    assign w_vpipe_nxt = (r_vpipe << 1) | DUT_LAT'(w_issue);
    assign w_cap_valid = r_vpipe[DUT_LAT-1] && !w_abort_act;
    // Drain ends on the edge that consumes the last in-flight pattern.
    assign w_drained   = (w_vpipe_nxt == '0);

    // Valid pipeline: cleared on a new run or an abort, else shifts each cycle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_vpipe <= '0;
      end else if (w_start_acc || w_abort_act) begin
        r_vpipe <= '0;
      end else begin
        r_vpipe <= w_vpipe_nxt;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = (num_patterns == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = (DUT_LAT > 0) ? ST_DRAIN : ST_DONE;
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_drained) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Pattern generator: seeded on start, advances once per issued pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= '0;
    end else if (w_load_lfsr) begin
      r_lfsr <= LFSR_SEED;
    end else if (w_issue) begin
      r_lfsr <= lfsr30_next(r_lfsr);
    end
  end

  // Remaining-pattern counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_start_acc) begin
      r_cnt <= num_patterns;
    end else if (w_issue) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Verdict: cleared on start or abort, latched from the DONE-cycle compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pass <= 1'b0;
    end else if (w_start_acc || w_abort_act) begin
      r_pass <= 1'b0;
    end else if (r_state == ST_DONE) begin
      r_pass <= (w_sig == golden);
    end
  end

  aig_bist_misr #(
    .W    (OUT_W),
    .TAPS (OUT_W'(MISR26_TAPS))
  ) u_misr (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_load  (w_start_acc),
    .i_en    (w_cap_valid),
    .i_seed  (MISR_SEED),
    .i_data  (f_in),
    .o_sig   (w_sig)
  );

  assign x_out     = r_lfsr;
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign pass      = r_pass;
  assign signature = w_sig;

endmodule

// File: tb/tb_aig_bench_bist.sv
// Directed bench for aig_bench_bist: loopback instance (DUT_LAT=0) and
// registered-wrapper instance (DUT_LAT=2).
module tb_aig_bench_bist;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: f_in wired straight back from x_out.
  logic        start_a = 1'b0, abort_a = 1'b0;
  logic [15:0] np_a = '0;
  logic [25:0] gold_a = '0;
  logic [29:0] x_out_a;
  logic [25:0] f_in_a;
  logic        busy_a, done_a, pass_a;
  logic [25:0] sig_a;

  assign f_in_a = x_out_a[25:0];

  aig_bench_bist #(.DUT_LAT(0)) u_dut_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start_a),
    .abort        (abort_a),
    .num_patterns (np_a),
    .golden       (gold_a),
    .x_out        (x_out_a),
    .f_in         (f_in_a),
    .busy         (busy_a),
    .done         (done_a),
    .pass         (pass_a),
    .signature    (sig_a)
  );

  // Instance B: two register stages between x_out and f_in.
  logic        start_b = 1'b0;
  logic [15:0] np_b = '0;
  logic [25:0] gold_b = '0;
  logic [29:0] x_out_b;
  logic [25:0] f_in_b, stg1_b, stg2_b;
  logic        busy_b, done_b, pass_b;
  logic [25:0] sig_b;

  always @(posedge clk) begin
    stg1_b <= x_out_b[25:0];
    stg2_b <= stg1_b;
  end
  assign f_in_b = stg2_b;

  aig_bench_bist #(.DUT_LAT(2)) u_dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start_b),
    .abort        (1'b0),
    .num_patterns (np_b),
    .golden       (gold_b),
    .x_out        (x_out_b),
    .f_in         (f_in_b),
    .busy         (busy_b),
    .done         (done_b),
    .pass         (pass_b),
    .signature    (sig_b)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One run on instance A; returns start-to-done latency and observations
  // around the DONE cycle. Latency saturates at 100 if done never shows.
  task automatic run_a(input int unsigned n, input logic [25:0] gold, input bit abort_in_done,
                       output int unsigned lat, output logic [29:0] x_first,
                       output logic busy_at_done, output logic done_after,
                       output logic busy_after);
    @(negedge clk);
    start_a = 1'b1;
    np_a    = 16'(n);
    gold_a  = gold;
    @(negedge clk);
    start_a = 1'b0;
    x_first = x_out_a;
    lat     = 1;
    while (done_a !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    busy_at_done = busy_a;
    if (abort_in_done) abort_a = 1'b1;
    @(negedge clk);
    abort_a    = 1'b0;
    done_after = done_a;
    busy_after = busy_a;
  endtask

  typedef struct {
    int unsigned n;
    logic [25:0] gold;
    logic [25:0] sig;
    logic        pass;
    logic [29:0] x_end;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int unsigned lat;
    logic [29:0] xf, xh;
    logic        bd, da, ba;
    int unsigned seen;

    // Loopback signatures worked by hand: x = 1,3,7,F,1E,3D,7B...
    vecs[0] = '{1, 26'h1,  26'h1,  1'b1, 30'h3};
    vecs[1] = '{2, 26'h0,  26'h0,  1'b1, 30'h7};
    vecs[2] = '{2, 26'h5,  26'h0,  1'b0, 30'h7};
    vecs[3] = '{3, 26'h7,  26'h7,  1'b1, 30'hF};
    vecs[4] = '{4, 26'h1,  26'h1,  1'b1, 30'h1E};
    vecs[5] = '{5, 26'h1D, 26'h1D, 1'b1, 30'h3D};
    vecs[6] = '{6, 26'h3F, 26'h6,  1'b0, 30'h7B};
    vecs[7] = '{0, 26'h0,  26'h0,  1'b1, 30'h7B};
    vecs[8] = '{0, 26'h1,  26'h0,  1'b0, 30'h7B};

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_x_out", 32'(x_out_a), 32'h0);
    chk("rst_sig",   32'(sig_a),   32'h0);
    chk("rst_busy",  32'(busy_a),  32'h0);
    chk("rst_done",  32'(done_a),  32'h0);
    chk("rst_pass",  32'(pass_a),  32'h0);
    rst_n = 1'b1;

    // Reset in the middle of a 10-pattern run.
    @(negedge clk);
    start_a = 1'b1; np_a = 16'd10; gold_a = '0;
    @(negedge clk);
    start_a = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrun_busy_before", 32'(busy_a), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_x_out", 32'(x_out_a), 32'h0);
    chk("midrun_rst_sig",   32'(sig_a),   32'h0);
    chk("midrun_rst_busy",  32'(busy_a),  32'h0);
    chk("midrun_rst_pass",  32'(pass_a),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_a === 1'b1) seen++;
    end
    chk("midrun_no_done", 32'(seen), 32'h0);

    // Table of loopback runs.
    for (int i = 0; i < 9; i++) begin
      run_a(vecs[i].n, vecs[i].gold, 1'b0, lat, xf, bd, da, ba);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].n + 1));
      chk($sformatf("v%0d_x_first", i), 32'(xf),
          (vecs[i].n != 0) ? 32'h1 : 32'(vecs[i].x_end));
      chk($sformatf("v%0d_busy_in_done", i), 32'(bd), 32'h1);
      chk($sformatf("v%0d_done_pulse", i), 32'(da), 32'h0);
      chk($sformatf("v%0d_busy_after", i), 32'(ba), 32'h0);
      chk($sformatf("v%0d_signature", i), 32'(sig_a), 32'(vecs[i].sig));
      chk($sformatf("v%0d_pass", i), 32'(pass_a), 32'(vecs[i].pass));
      chk($sformatf("v%0d_x_end", i), 32'(x_out_a), 32'(vecs[i].x_end));
    end

    // Abort held during DONE has no effect.
    run_a(1, 26'h1, 1'b1, lat, xf, bd, da, ba);
    chk("abort_in_done_latency", 32'(lat), 32'h2);
    chk("abort_in_done_pass", 32'(pass_a), 32'h1);

    // Abort in cycle 3 of an 8-pattern run; start pulsed while busy.
    @(negedge clk);
    start_a = 1'b1; np_a = 16'd8; gold_a = 26'h0;
    @(negedge clk);
    start_a = 1'b0;
    seen = 0;
    @(negedge clk);
    start_a = 1'b1; np_a = 16'd0;
    @(negedge clk);
    start_a = 1'b0;
    if (done_a === 1'b1) seen++;
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    if (done_a === 1'b1) seen++;
    chk("abort_busy", 32'(busy_a), 32'h0);
    chk("abort_pass", 32'(pass_a), 32'h0);
    xh = x_out_a;
    repeat (3) begin
      @(negedge clk);
      if (done_a === 1'b1) seen++;
    end
    chk("abort_no_done", 32'(seen), 32'h0);
    chk("abort_x_hold", 32'(x_out_a), 32'(xh));

    // Registered wrapper, DUT_LAT=2, N=2.
    @(negedge clk);
    start_b = 1'b1; np_b = 16'd2; gold_b = 26'h0;
    @(negedge clk);
    start_b = 1'b0;
    lat  = 1;
    seen = 0;
    while (done_b !== 1'b1 && lat < 100) begin
      if (busy_b !== 1'b1) seen++;
      @(negedge clk);
      lat++;
    end
    chk("lat2_latency", 32'(lat), 32'h5);
    chk("lat2_busy_in_done", 32'(busy_b), 32'h1);
    chk("lat2_busy_gaps", 32'(seen), 32'h0);
    chk("lat2_signature", 32'(sig_b), 32'h0);
    @(negedge clk);
    chk("lat2_pass", 32'(pass_b), 32'h1);
    chk("lat2_done_pulse", 32'(done_b), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aig_bench_bist.md
Name: aig_bench_bist

Overview:
- Self-test harness for one combinational AIG benchmark netlist from the dataset flow (30 inputs x0..x29, 26 outputs f1..f26).
- Drives the benchmark inputs from a 30-bit LFSR and compacts its outputs into a 26-bit MISR signature.
- Compares the signature against a supplied golden value and reports pass or fail.
- Sits on the opposite side of the netlist's pin interface: it generates what the benchmark consumes and consumes what the benchmark produces. It is used for equivalence regression of the RESYN2 and other re-synthesised variants.

Parameters:
- IN_W, 30, benchmark input count (LFSR width; taps fixed for 30).
- OUT_W, 26, benchmark output count (MISR width; taps fixed for 26).
- CNT_W, 16, pattern counter width.
- DUT_LAT, 0, cycles from x_out change to valid f_in. Legal range 0..3; nonzero values cover registered wrappers.
- LFSR_SEED, 30'h1, LFSR load value on start. Must be nonzero.
- MISR_SEED, 26'h0, MISR load value on start.

Ports:
- clk, in, 1, single clock.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, begin a run. Sampled only in IDLE.
- abort, in, 1, synchronous cancel of a run in progress.
- num_patterns, in, CNT_W, pattern count. Sampled with start.
- golden, in, OUT_W, expected signature. Sampled in the DONE cycle.
- x_out, out, IN_W, benchmark inputs (x_out[i] drives xi).
- f_in, in, OUT_W, benchmark outputs (f_in[j] driven by f(j+1)).
- busy, out, 1, high from start acceptance until the DONE cycle, inclusive.
- done, out, 1, single-cycle pulse at end of run.
- pass, out, 1, signature==golden. Registered in DONE; held until the next start.
- signature, out, OUT_W, MISR contents. Held after the run.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, x_out=0, signature=0, busy=0, done=0, pass=0, counters and valid pipeline cleared.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE, start=1: load lfsr=LFSR_SEED, misr=MISR_SEED, cnt=num_patterns; pass<=0; busy<=1.
  - num_patterns==0 → go to DONE.
  - Otherwise → go to RUN.
- RUN, each cycle: x_out=lfsr (x_out is the lfsr register). Issue one pattern: lfsr advances, cnt decrements, issue bit enters a DUT_LAT-deep valid shift register.
  - After the cycle that issues the last pattern (cnt 1→0) → go to DRAIN if DUT_LAT>0, else DONE.
- DRAIN: wait until the valid pipeline is empty → go to DONE.
- DONE: done=1 for one cycle; pass<=(misr==golden); busy deasserts next cycle; → IDLE.
- LFSR: Fibonacci, taps 30,6,4,1. next = {s[28:0], s[29]^s[5]^s[3]^s[0]}.
- MISR: taps 26,6,2,1. Updates only when the capture-valid flag is set. next = {m[24:0], m[25]^m[5]^m[1]^m[0]} ^ f_in.
- Capture-valid flag:
  - DUT_LAT=0: equals the issue flag, so f_in is captured at the same edge that advances the LFSR.
  - DUT_LAT=k: issue flag delayed k cycles.
- x_out holds its last value in DRAIN, DONE and IDLE; it is not cleared.
- start while busy: ignored.
- abort in RUN or DRAIN: → IDLE next edge, busy=0, no done pulse, pass=0, signature holds partial value.
- abort in IDLE or DONE: ignored; DONE completes normally.
- start and abort together in IDLE: start wins.
- cnt never wraps: a decrement from 0 cannot happen by construction.
- Run length: N patterns → done asserted exactly N+DUT_LAT+1 cycles after the start edge. For N=0 it is 1 cycle.

Decomposition:
- Package aig_bist_pkg holds:
  - state enum;
  - LFSR30 and MISR26 tap constants;
  - functions lfsr30_next and misr26_next.
- One sub-module, aig_bist_misr: OUT_W-wide MISR with load, enable, seed and data ports. It is reusable for other benchmark output widths.
- LFSR, counter and FSM stay in the top.

Test Plan:
- Reset mid-RUN (rst_n low at pattern 5 of 10) → all outputs 0 immediately; no done pulse; next start runs cleanly.
- num_patterns=0, start → done 1 cycle later; signature=26'h0; pass=1 iff golden=0; x_out unchanged.
- Loopback f_in=x_out[25:0], DUT_LAT=0, N=1 → x_out=30'h1 during RUN; signature=26'h1; golden=26'h1 → pass=1.
- Same loopback, N=2 → x_out sequence 30'h1, 30'h3; signature=26'h0; done exactly 3 cycles after start.
- DUT_LAT=2 with a 2-stage register on f_in, N=2 → signature=26'h0 (same as the previous scenario); done 5 cycles after start; busy high through DONE.
- abort in cycle 3 of an N=8 run → busy low next cycle, no done, pass=0; start pulsed while busy has no effect.
